// File: rtl/pkt_merge_arbiter.sv
// Merges the aggregator and parser-bypass AXI-Stream inputs into one output stream.
// Grants are held for whole packets; weighted round-robin applies only under contention.
module pkt_merge_arbiter #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned WEIGHT_AGG         = 2,
    parameter int unsigned WEIGHT_BYP         = 1
) (
    input  logic                               axis_aclk,
    input  logic                               axis_resetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]       s_axis_agg_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]     s_axis_agg_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]      s_axis_agg_tuser,
    input  logic                               s_axis_agg_tvalid,
    input  logic                               s_axis_agg_tlast,
    output logic                               s_axis_agg_tready,

    input  logic [C_AXIS_DATA_WIDTH-1:0]       s_axis_byp_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]     s_axis_byp_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]      s_axis_byp_tuser,
    input  logic                               s_axis_byp_tvalid,
    input  logic                               s_axis_byp_tlast,
    output logic                               s_axis_byp_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,

    output logic [31:0]                        pkt_cnt_agg,
    output logic [31:0]                        pkt_cnt_byp,
    output logic                               grant_agg,
    output logic                               grant_byp
);
    localparam int unsigned BURST_W = 4;
    localparam logic [BURST_W-1:0] BURST_MAX = '1;

    typedef enum logic [1:0] {IDLE, GRANT_AGG, GRANT_BYP} state_t;

    state_t               state;
    logic                 last_byp;
    logic [BURST_W-1:0]   burst_cnt;
    logic [BURST_W-1:0]   weight_c;
    logic                 pick_byp_c;

    // Arbitration choice evaluated in IDLE; a single requester always wins
    always_comb begin
        weight_c   = last_byp ? BURST_W'(WEIGHT_BYP) : BURST_W'(WEIGHT_AGG);
        pick_byp_c = last_byp;
        if (s_axis_agg_tvalid && !s_axis_byp_tvalid) begin
            pick_byp_c = 1'b0;
        end else if (!s_axis_agg_tvalid && s_axis_byp_tvalid) begin
            pick_byp_c = 1'b1;
        end else if (burst_cnt >= weight_c) begin
            pick_byp_c = !last_byp;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state       <= IDLE;
            last_byp    <= 1'b1;
            burst_cnt   <= '0;
            pkt_cnt_agg <= '0;
            pkt_cnt_byp <= '0;
            grant_agg   <= 1'b0;
            grant_byp   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_agg_tvalid || s_axis_byp_tvalid) begin
                        state     <= pick_byp_c ? GRANT_BYP : GRANT_AGG;
                        grant_agg <= !pick_byp_c;
                        grant_byp <= pick_byp_c;
                        if (pick_byp_c == last_byp) begin
                            if (burst_cnt != BURST_MAX) begin
                                burst_cnt <= burst_cnt + BURST_W'(1);
                            end
                        end else begin
                            burst_cnt <= BURST_W'(1);
                            last_byp  <= pick_byp_c;
                        end
                    end
                end
                GRANT_AGG: begin
                    if (s_axis_agg_tvalid && m_axis_tready && s_axis_agg_tlast) begin
                        pkt_cnt_agg <= pkt_cnt_agg + 32'd1;
                        state       <= IDLE;
                        grant_agg   <= 1'b0;
                    end
                end
                GRANT_BYP: begin
                    if (s_axis_byp_tvalid && m_axis_tready && s_axis_byp_tlast) begin
                        pkt_cnt_byp <= pkt_cnt_byp + 32'd1;
                        state       <= IDLE;
                        grant_byp   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant_agg <= 1'b0;
                    grant_byp <= 1'b0;
                end
            endcase
        end
    end

    // Datapath is a pure mux; only valid/ready are gated by the grant
    assign s_axis_agg_tready = grant_agg & m_axis_tready;
    assign s_axis_byp_tready = grant_byp & m_axis_tready;
    assign m_axis_tvalid     = (grant_agg & s_axis_agg_tvalid) | (grant_byp & s_axis_byp_tvalid);
    assign m_axis_tdata      = grant_byp ? s_axis_byp_tdata : s_axis_agg_tdata;
    assign m_axis_tkeep      = grant_byp ? s_axis_byp_tkeep : s_axis_agg_tkeep;
    assign m_axis_tuser      = grant_byp ? s_axis_byp_tuser : s_axis_agg_tuser;
    assign m_axis_tlast      = grant_byp ? s_axis_byp_tlast : s_axis_agg_tlast;

endmodule

// File: doc/pkt_merge_arbiter.md
PKT_MERGE_ARBITER -- requirements
Module: pkt_merge_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256, tdata width of all three streams.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, tuser width of all three streams.
REQ-003 SHALL have parameter WEIGHT_AGG, default 2, max consecutive aggregator packets granted under contention (1..15).
REQ-004 SHALL have parameter WEIGHT_BYP, default 1, max consecutive bypass packets granted under contention (1..15).
REQ-005 SHALL have port axis_aclk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port axis_resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports s_axis_agg_tdata/tkeep/tuser/tvalid/tlast (inputs) and s_axis_agg_tready (output), widths DATA, DATA/8, TUSER, 1, 1, 1; aggregator result stream.
REQ-008 SHALL have ports s_axis_byp_tdata/tkeep/tuser/tvalid/tlast (inputs) and s_axis_byp_tready (output), same widths; parser bypass (OQ) stream.
REQ-009 SHALL have ports m_axis_tdata/tkeep/tuser/tvalid/tlast (outputs) and m_axis_tready (input), same widths; merged stream to output queues.
REQ-010 SHALL have pkt_cnt_agg and pkt_cnt_byp, outputs, 32 each, packets forwarded per input.
REQ-011 SHALL have grant_agg and grant_byp, outputs, 1 each, one-hot current grant (both 0 in IDLE).

Function
REQ-012 SHALL implement FSM states IDLE, GRANT_AGG, GRANT_BYP; registered state.
REQ-013 IDLE: both s_*_tready=0, m_axis_tvalid=0; no transfer occurs in IDLE (one-cycle arbitration bubble per packet).
REQ-014 IDLE, only one s_*_tvalid=1: next state grants that input.
REQ-015 IDLE, both tvalid=1: if burst_cnt < WEIGHT of last_grant, re-grant last_grant; else grant the other input.
REQ-016 On entering a GRANT state: if new grant equals last_grant, burst_cnt increments (saturating at 15); else burst_cnt=1 and last_grant updates.
REQ-017 IDLE, neither valid: remain IDLE, last_grant/burst_cnt unchanged.
REQ-018 GRANT_X: m_axis_* data/keep/user/last/valid driven combinationally from input X; s_axis_X_tready = m_axis_tready; other input tready=0.
REQ-019 Transfer = tvalid & tready on granted input; input X tvalid gaps mid-packet SHALL NOT release grant.
REQ-020 Transfer with tlast=1: pkt_cnt_X increments by 1 (wraps 0xFFFFFFFF->0); next state IDLE.
REQ-021 Grant SHALL change only at packet boundaries; no beat interleaving between inputs.
REQ-022 Non-granted input data SHALL be ignored; m_axis_tdata value when m_axis_tvalid=0 is don't-care.
REQ-023 Single-beat packets (tlast on first beat) SHALL complete in one GRANT cycle.
REQ-024 tkeep/tuser SHALL pass unmodified; block SHALL NOT inspect or alter packet content.

Reset
REQ-025 axis_resetn=0 SHALL immediately force state=IDLE, last_grant=BYP, burst_cnt=0, pkt_cnt_*=0, grant_*=0.
REQ-026 During and after reset until first arbitration: m_axis_tvalid=0, s_axis_agg_tready=0, s_axis_byp_tready=0.
REQ-027 Reset mid-packet SHALL abandon the packet; no counter increment; resumes arbitration from IDLE one cycle after deassertion.

Verification
REQ-028 Only agg sends 3-beat packet, m_tready=1 -> 1 IDLE cycle, 3 output beats with identical data, tlast on beat 3, pkt_cnt_agg=1.
REQ-029 Both inputs continuously valid, 1-beat packets, default weights -> grant order BYP, AGG, AGG, BYP, AGG, AGG.
REQ-030 m_tready=0 for 4 cycles mid agg packet while byp valid -> agg beat held stable, s_axis_byp_tready=0, no grant change.
REQ-031 agg tvalid gap of 3 cycles mid-packet, byp valid -> grant_agg stays 1, m_axis_tvalid=0 during gap, packet completes intact.
REQ-032 axis_resetn pulsed low on beat 2 of 4-beat byp packet -> outputs/counters 0 immediately; next new packet forwarded from IDLE correctly.
REQ-033 pkt_cnt_byp preset via force to 0xFFFFFFFF, one byp packet -> pkt_cnt_byp=0.
